// File: rtl/irq_ctrl.sv
// irq_ctrl: NCH-channel fixed-priority interrupt controller for a single
// IRQ/IC CPU interface. Lowest channel index wins. The handshake is
// registered: request, then ACK (in service), then EOI (back to idle).
// Optional feature macro: IRQ_EDGE_EN. When it is defined, rising-edge
// requests are latched until acknowledged. Otherwise PEND is a one-cycle
// registered copy of the IRQ_IN levels.
module irq_ctrl #(
  parameter int NCH = 16,
  parameter int ICW = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NCH-1:0]   IRQ_IN,
  input  logic             MWE,
  input  logic [NCH-1:0]   MDATA,
  input  logic             ACK,
  input  logic             EOI,
  output logic             IRQ,
  output logic [ICW-1:0]   IC,
  output logic             BUSY,
  output logic [NCH-1:0]   PEND
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  state_t           state, stateNext;
  logic             irqQ, irqNext;
  logic [ICW-1:0]   icQ, icNext;
  logic             busyQ, busyNext;
  logic [NCH-1:0]   mask;
  logic [NCH-1:0]   pend, pendNext;
  logic [NCH-1:0]   candidate;
  logic             ackTake;

  // Lowest set index wins; scanning downward lets the last hit be the lowest.
  function automatic logic [ICW-1:0] winnerIdx(input logic [NCH-1:0] c);
    logic [ICW-1:0] idx;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (c[i]) idx = ICW'(i);
    end
    return idx;
  endfunction

  assign candidate = pend & mask;
  assign ackTake   = (state == REQ) && ACK;

`ifdef IRQ_EDGE_EN
  logic [NCH-1:0] irqInDly;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] clrMask;

  assign rise    = IRQ_IN & ~irqInDly;
  assign clrMask = ackTake ? (NCH'(1) << icQ) : '0;
  // A rising edge in the ACK cycle re-sets the bit: set has priority over clear.
  assign pendNext = (pend & ~clrMask) | rise;

  // Delay register used for rising-edge detection.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) irqInDly <= '0;
    else      irqInDly <= IRQ_IN;
  end
`else
  // Level mode: the pending vector simply follows the request lines.
  assign pendNext = IRQ_IN;
`endif

  // Pending vector and enable mask; a mask write takes effect after this edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pend <= '0;
      mask <= '0;
    end else begin
      pend <= pendNext;
      if (MWE) mask <= MDATA;
    end
  end

  // Next-state and registered-output values for the handshake FSM.
  always_comb begin
    stateNext = state;
    irqNext   = irqQ;
    icNext    = icQ;
    busyNext  = busyQ;
    case (state)
      IDLE: begin
        if (|candidate) begin
          icNext    = winnerIdx(candidate);
          irqNext   = 1'b1;
          stateNext = REQ;
        end
      end
      REQ: begin
        if (ACK) begin
          irqNext   = 1'b0;
          busyNext  = 1'b1;
          stateNext = SERV;
        end else if (!candidate[icQ]) begin
          // Request withdrawn or masked before ACK; IC keeps its last value.
          irqNext   = 1'b0;
          stateNext = IDLE;
        end
      end
      SERV: begin
        if (EOI) begin
          busyNext  = 1'b0;
          stateNext = IDLE;
        end
      end
      default: begin
        irqNext   = 1'b0;
        busyNext  = 1'b0;
        stateNext = IDLE;
      end
    endcase
  end

  // FSM state and handshake output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      irqQ  <= 1'b0;
      icQ   <= '0;
      busyQ <= 1'b0;
    end else begin
      state <= stateNext;
      irqQ  <= irqNext;
      icQ   <= icNext;
      busyQ <= busyNext;
    end
  end

  assign IRQ  = irqQ;
  assign IC   = icQ;
  assign BUSY = busyQ;
  assign PEND = pend;

endmodule
